// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection (stall + bubble insertion).

// Per-operand forwarding mux: EX/MEM beats MEM/WB, register 0 never forwards,
// and the operand reads as zero while the EX slot is empty.
module id_ex_fwd #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          en,
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_alu_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_wdata,
  output logic [DW-1:0] fwd_data
);
  logic hit_exmem, hit_memwb;

  assign hit_exmem = exmem_reg_write & (exmem_rd != '0) & (exmem_rd == src);
  assign hit_memwb = memwb_reg_write & (memwb_rd != '0) & (memwb_rd == src);

  // Priority select of the freshest producer for this operand
  always_comb begin
    fwd_data = '0;
    if (en) begin
      if (hit_exmem)      fwd_data = exmem_alu_result;
      else if (hit_memwb) fwd_data = memwb_wdata;
      else                fwd_data = reg_data;
    end
  end
endmodule

module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [1:0]    id_alu_op,
  input  logic [5:0]    id_funct,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_alu_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_wdata,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [3:0]    alu_opcode,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
);
  localparam int NOPS = 2;  // operand A (rs) and B (rt)

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dest;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [3:0]    opcode;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } ex_reg_t;

  ex_reg_t ex_d, ex_q;
  logic [3:0] op_dec;
  logic [NOPS-1:0][RW-1:0] op_src;
  logic [NOPS-1:0][DW-1:0] op_reg, op_fwd;

  // Load-use: the load in EX cannot supply its data to the ID instruction in time
  assign stall = ex_q.valid & ex_q.mem_read & (ex_q.dest != '0) & id_valid &
                 ((ex_q.dest == id_rs) | (ex_q.dest == id_rt)) & ~flush;

  // ALU control decode from alu_op / funct
  always_comb begin
    op_dec = 4'b0010;
    case (id_alu_op)
      2'b01: op_dec = 4'b0110;
      2'b10: begin
        case (id_funct)
          6'b100010: op_dec = 4'b0110;
          6'b100100: op_dec = 4'b0000;
          6'b100101: op_dec = 4'b0001;
          6'b100110: op_dec = 4'b1111;
          6'b101010: op_dec = 4'b0111;
          default:   op_dec = 4'b0010;
        endcase
      end
      default: op_dec = 4'b0010;
    endcase
  end

  // Next EX contents: flush or stall loads an all-zero bubble
  always_comb begin
    ex_d = '0;
    if (!(flush | stall)) begin
      ex_d.valid      = id_valid;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.dest       = id_reg_dst ? id_rd : id_rt;
      ex_d.rs_data    = id_rs_data;
      ex_d.rt_data    = id_rt_data;
      ex_d.imm        = id_imm;
      ex_d.opcode     = op_dec;
      ex_d.alu_src    = id_alu_src;
      // An empty ID slot must never produce side effects downstream
      ex_d.reg_write  = id_valid & id_reg_write;
      ex_d.mem_read   = id_valid & id_mem_read;
      ex_d.mem_write  = id_valid & id_mem_write;
      ex_d.mem_to_reg = id_valid & id_mem_to_reg;
    end
  end

  // ID/EX register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign op_src = {ex_q.rt, ex_q.rs};
  assign op_reg = {ex_q.rt_data, ex_q.rs_data};

  for (genvar g = 0; g < NOPS; g++) begin : g_fwd
    id_ex_fwd #(.DW(DW), .RW(RW)) u_fwd (
      .en               (ex_q.valid),
      .src              (op_src[g]),
      .reg_data         (op_reg[g]),
      .exmem_reg_write  (exmem_reg_write),
      .exmem_rd         (exmem_rd),
      .exmem_alu_result (exmem_alu_result),
      .memwb_reg_write  (memwb_reg_write),
      .memwb_rd         (memwb_rd),
      .memwb_wdata      (memwb_wdata),
      .fwd_data         (op_fwd[g])
    );
  end

  assign ex_valid      = ex_q.valid;
  assign alu_in1       = op_fwd[0];
  assign alu_in2       = !ex_q.valid ? '0 : (ex_q.alu_src ? ex_q.imm : op_fwd[1]);
  assign ex_store_data = op_fwd[1];
  assign alu_opcode    = ex_q.opcode;
  assign ex_dest       = ex_q.dest;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid & ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.valid & ex_q.mem_to_reg;
endmodule
